// File: rtl/uart_pkg.sv
// Shared constants, state encodings and baud-divider helper for the UART transceiver.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // RX_BREAK holds off rearming after a framing error until the line idles high.
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    // Clocks per bit, rounded to nearest; callers must keep the result >= 4.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_engine.sv
// 8N1 receiver: input synchronizer, start-bit qualification, mid-bit sampling
// and a one-cycle valid strobe for each correctly framed byte.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 r_meta, r_sync, r_prev;
    rx_state_e            r_state, w_state;
    logic [CNT_W-1:0]     r_cnt, w_cnt;
    logic [BIT_W-1:0]     r_bit, w_bit;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic [DATA_BITS-1:0] r_data, w_data;
    logic                 r_valid, w_valid;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection;
    // resets to the idle-high line level so reset release never looks like a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Receiver state, bit timing, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_data  <= w_data;
            r_valid <= w_valid;
        end
    end

    // Next-state logic: qualify the start bit at its centre, then sample each
    // following bit one bit-time apart; only a high stop bit publishes the byte.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_data  = r_data;
        w_valid = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt = '0;
                w_bit = '0;
                if (r_prev == STOP_BIT && r_sync == START_BIT) begin
                    w_state = RX_START;
                end else begin
                    w_state = RX_IDLE;
                end
            end
            RX_START: begin
                if (r_cnt == HALF_END) begin
                    w_cnt = '0;
                    if (r_sync == START_BIT) begin
                        w_state = RX_DATA;
                    end else begin
                        w_state = RX_IDLE;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (r_cnt == BIT_END) begin
                    w_cnt   = '0;
                    w_shift = {r_sync, r_shift[DATA_BITS-1:1]};
                    w_bit   = r_bit + BIT_W'(1);
                    if (r_bit == BIT_LAST) begin
                        w_state = RX_STOP;
                    end else begin
                        w_state = RX_DATA;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (r_cnt == BIT_END) begin
                    w_cnt = '0;
                    if (r_sync == STOP_BIT) begin
                        w_data  = r_shift;
                        w_valid = 1'b1;
                        w_state = RX_IDLE;
                    end else begin
                        w_state = RX_BREAK;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            RX_BREAK: begin
                w_cnt = '0;
                if (r_sync == STOP_BIT) begin
                    w_state = RX_IDLE;
                end else begin
                    w_state = RX_BREAK;
                end
            end
            default: begin
                w_state = RX_IDLE;
                w_cnt   = '0;
                w_bit   = '0;
            end
        endcase
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: inline transmit shifter with a registered ready
// handshake, plus an independent receive engine.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic       clk,
    input  logic       reset,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_transmit
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    tx_state_e            r_state, w_state;
    logic [CNT_W-1:0]     r_cnt, w_cnt;
    logic [BIT_W-1:0]     r_bit, w_bit;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic                 r_tx, w_tx;
    logic                 r_ready, w_ready;

    // Transmit state register; the line and ready flag are registered so the
    // line drops exactly one cycle after acceptance and ready is glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_ready <= w_ready;
        end
    end

    // Transmit next-state logic. The shift register always presents the current
    // data bit at [0]; ready reasserts on the final stop-bit clock, so a waiting
    // requester starts the next frame after a single handshake cycle.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_tx    = r_tx;
        w_ready = r_ready;
        case (r_state)
            TX_IDLE: begin
                w_cnt = '0;
                w_bit = '0;
                if (tx_transmit && r_ready) begin
                    w_state = TX_START;
                    w_shift = tx_data;
                    w_tx    = START_BIT;
                    w_ready = 1'b0;
                end else begin
                    w_state = TX_IDLE;
                    w_tx    = STOP_BIT;
                    w_ready = 1'b1;
                end
            end
            TX_START: begin
                if (r_cnt == BIT_END) begin
                    w_cnt   = '0;
                    w_state = TX_DATA;
                    w_tx    = r_shift[0];
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (r_cnt == BIT_END) begin
                    w_cnt = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state = TX_STOP;
                        w_tx    = STOP_BIT;
                    end else begin
                        w_state = TX_DATA;
                        w_bit   = r_bit + BIT_W'(1);
                        w_shift = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx    = r_shift[1];
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (r_cnt == BIT_END) begin
                    w_cnt   = '0;
                    w_state = TX_IDLE;
                    w_tx    = STOP_BIT;
                    w_ready = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state = TX_IDLE;
                w_cnt   = '0;
                w_bit   = '0;
                w_tx    = STOP_BIT;
                w_ready = 1'b1;
            end
        endcase
    end

    assign tx       = r_tx;
    assign tx_ready = r_ready;

    uart_rx_engine #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst_n   (reset),
        .i_rx    (rx),
        .o_data  (rx_data),
        .o_valid (rx_valid)
    );

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver at 16 clocks per bit; received bytes are
// checked by a queue-based scoreboard fed from the stimulus side.
module tb_uart_transceiver;

    logic       clk;
    logic       reset;
    logic       tx;
    logic       rx_line;
    logic       rx_drv;
    logic       loopback;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_transmit;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    int cyc      = 0;
    int last_valid_cyc = 0;
    int start_cyc = 0;
    logic [7:0] exp_q[$];

    assign rx_line = loopback ? tx : rx_drv;

    uart_transceiver #(
        .CLK_FREQ (16),
        .BAUD     (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx          (tx),
        .rx          (rx_line),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_transmit (tx_transmit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: each rx_valid pulse pops one expected byte.
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rx_unexpected: got rx_valid with rx_data=%02h, required no pulse", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", int'(rx_data), int'(e));
                end
            end
        end
    end

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rx_drv    = 1'b0;
        start_cyc = cyc;
        wait_cycles(16);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            wait_cycles(16);
        end
        rx_drv = stop;
        wait_cycles(16);
        rx_drv = 1'b1;
    endtask

    task automatic tx_send(input logic [7:0] b, input bit expect_rx);
        int guard;
        guard = 0;
        while (tx_ready !== 1'b1 && guard < 400) begin
            wait_cycles(1);
            guard++;
        end
        if (tx_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL tx_ready_timeout: got tx_ready=%b, required 1 within 400 cycles", tx_ready);
        end else begin
            if (expect_rx) exp_q.push_back(b);
            tx_data     = b;
            tx_transmit = 1'b1;
            wait_cycles(1);
            tx_transmit = 1'b0;
        end
    endtask

    initial begin : stimulus
        logic [9:0] exp_bits;
        bit         idle_ok;
        int         v0;

        reset       = 1'b0;
        rx_drv      = 1'b1;
        loopback    = 1'b0;
        tx_data     = 8'h00;
        tx_transmit = 1'b0;

        // Reset state, then unchanged after release.
        wait_cycles(5);
        check("rst_tx",       int'(tx),       1);
        check("rst_tx_ready", int'(tx_ready), 1);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_rx_data",  int'(rx_data),  8'h00);
        reset = 1'b1;
        wait_cycles(3);
        check("post_rst_tx",       int'(tx),       1);
        check("post_rst_tx_ready", int'(tx_ready), 1);
        check("post_rst_rx_valid", int'(rx_valid), 0);
        check("post_rst_rx_data",  int'(rx_data),  8'h00);

        // TX 0xA5: start, 1,0,1,0,0,1,0,1 (LSB first), stop.
        exp_bits    = 10'b1_1010_0101_0;
        tx_data     = 8'hA5;
        tx_transmit = 1'b1;
        wait_cycles(1);
        tx_transmit = 1'b0;
        check("tx_ready_drop", int'(tx_ready), 0);
        check("tx_fall",       int'(tx),       0);
        for (int k = 0; k < 10; k++) begin
            wait_cycles(k == 0 ? 8 : 16);
            check($sformatf("tx_bit%0d", k), int'(tx), int'(exp_bits[k]));
        end
        wait_cycles(7);
        check("tx_ready_at_159", int'(tx_ready), 0);
        wait_cycles(1);
        check("tx_ready_at_160", int'(tx_ready), 1);
        check("tx_idle_at_160",  int'(tx),       1);

        // tx_transmit held two cycles: exactly one frame.
        tx_data     = 8'h3C;
        tx_transmit = 1'b1;
        wait_cycles(2);
        tx_transmit = 1'b0;
        wait_cycles(159);
        check("hold2_ready_back", int'(tx_ready), 1);
        idle_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wait_cycles(1);
            if (tx !== 1'b1 || tx_ready !== 1'b1) idle_ok = 1'b0;
        end
        check("hold2_single_frame", int'(idle_ok), 1);

        // RX 0x3C good frame.
        v0 = n_valid;
        exp_q.push_back(8'h3C);
        rx_frame(8'h3C, 1'b1);
        wait_cycles(4);
        check("rx3c_pulses", n_valid - v0, 1);
        check("rx3c_latency_ok",
              int'((last_valid_cyc - start_cyc) >= 153 && (last_valid_cyc - start_cyc) <= 157), 1);
        wait_cycles(100);
        check("rx3c_hold", int'(rx_data), 8'h3C);

        // Framing error then a good frame.
        v0 = n_valid;
        rx_frame(8'h55, 1'b0);
        wait_cycles(20);
        check("ferr_no_pulse", n_valid - v0, 0);
        check("ferr_data_kept", int'(rx_data), 8'h3C);
        exp_q.push_back(8'h81);
        rx_frame(8'h81, 1'b1);
        wait_cycles(4);
        check("after_ferr_pulse", n_valid - v0, 1);
        check("after_ferr_data", int'(rx_data), 8'h81);

        // Short glitch: no byte, and the receiver still accepts a frame after.
        v0 = n_valid;
        rx_drv = 1'b0;
        wait_cycles(4);
        rx_drv = 1'b1;
        wait_cycles(40);
        check("glitch_no_pulse", n_valid - v0, 0);
        exp_q.push_back(8'h42);
        rx_frame(8'h42, 1'b1);
        wait_cycles(4);
        check("glitch_then_good", n_valid - v0, 1);

        // Loopback: three back-to-back bytes.
        loopback = 1'b1;
        wait_cycles(4);
        v0 = n_valid;
        tx_send(8'h00, 1'b1);
        tx_send(8'hFF, 1'b1);
        tx_send(8'h5A, 1'b1);
        wait_cycles(200);
        check("loop_pulses", n_valid - v0, 3);
        check("loop_drained", exp_q.size(), 0);

        // Reset in the middle of the second frame of a pair.
        v0 = n_valid;
        tx_send(8'h11, 1'b1);
        tx_send(8'h22, 1'b0);
        wait_cycles(80);
        reset = 1'b0;
        #1;
        check("midrst_tx_high",  int'(tx),       1);
        check("midrst_tx_ready", int'(tx_ready), 1);
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(200);
        check("midrst_pulses",  n_valid - v0, 1);
        check("midrst_rx_data", int'(rx_data), 8'h00);
        check("final_drained",  exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
